rom_read_arbiter: RTL and testbench

//  Shares one 32x5 read-only lookup ROM (negedge-registered read) between NREQ requesters.

---
 rtl/rom_read_arbiter.sv | 134 +++++++++++++
 tb/tb_rom_read_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Shares one negedge-registered read-only lookup ROM between NREQ requesters.
//   Round-robin arbitration with a valid/ready request handshake; at most one
//   read is accepted per clock and its data returns one cycle after acceptance.
//
// Optional feature macro: ROM_ARB_LOCK_EN
//   Adds the lock port and an UNLOCKED/LOCKED FSM that lets one requester
//   keep the grant for back-to-back reads.
//
// Parameters
//   NREQ  number of requesters (2..4)
//   AW    ROM address width
//   DW    ROM data width
//
// Ports
//   clk       single clock, all state on posedge
//   resetn    asynchronous active-low reset
//   req       per-requester request valid
//   addr      flattened addresses, requester i at [i*AW +: AW]
//   gnt       combinational accept (transfer when req[i] & gnt[i] at posedge)
//   rom_addr  registered address to the ROM
//   rom_data  ROM read data, stable by the posedge after rom_addr changes
//   rvalid    one-hot, one-cycle: rdata belongs to requester i
//   rdata     registered read data, holds when rvalid is low
//   lock      (ROM_ARB_LOCK_EN only) hold grant for requester i
module rom_read_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata
`ifdef ROM_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]    lock
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0] last;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] issued_id;
  logic           issued;
  logic           xfer;

`ifdef ROM_ARB_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
  lock_state_t    state;
  logic [IDW-1:0] owner;
`endif

  // Round-robin search starting just after the previous winner.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
`ifdef ROM_ARB_LOCK_EN
    // While locked only the owner may be accepted.
    if (state == LOCKED) begin
      found  = req[owner];
      winner = owner;
    end
`endif
    xfer = found & resetn;
    gnt  = '0;
    if (xfer) gnt[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rom_addr  <= '0;
      rdata     <= '0;
      rvalid    <= '0;
      issued    <= 1'b0;
      issued_id <= '0;
      last      <= IDW'(NREQ - 1);
    end else begin
      // Stage 1: latch the winner's address; ROM samples it on the coming negedge.
      if (xfer) begin
        rom_addr  <= addr[int'(winner)*AW +: AW];
        issued    <= 1'b1;
        issued_id <= winner;
        last      <= winner;
      end else begin
        issued    <= 1'b0;
      end
      // Stage 2: capture ROM data only for an issued read so idle cycles hold rdata.
      if (issued) begin
        rdata  <= rom_data;
        rvalid <= NREQ'(1) << issued_id;
      end else begin
        rvalid <= '0;
      end
    end
  end

`ifdef ROM_ARB_LOCK_EN
  // Only the owner transfers while locked, so last already equals owner
  // when the lock is released and round-robin resumes after it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= UNLOCKED;
      owner <= '0;
    end else begin
      case (state)
        UNLOCKED: if (xfer && lock[winner]) begin
          state <= LOCKED;
          owner <= winner;
        end
        LOCKED: if (!lock[owner]) state <= UNLOCKED;
        default: state <= UNLOCKED;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter
//   Directed stimulus for rom_read_arbiter with NREQ=3 and a negedge-registered
//   ROM model returning ~rom_addr. Accepted reads push their expected
//   requester, data and arrival cycle into a queue; a monitor pops and
//   compares whenever rvalid is seen.
module tb_rom_read_arbiter;

  logic       clk;
  logic       resetn;
  logic [2:0] req;
  logic [14:0] addr;
  logic [2:0] gnt;
  logic [4:0] rom_addr;
  logic [4:0] rom_data;
  logic [2:0] rvalid;
  logic [4:0] rdata;
  logic [2:0] lock;

  rom_read_arbiter #(.NREQ(3), .AW(5), .DW(5)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rvalid   (rvalid),
    .rdata    (rdata)
`ifdef ROM_ARB_LOCK_EN
    ,
    .lock     (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: registered on negedge, content is the bitwise inverse of the address.
  always @(negedge clk) rom_data <= ~rom_addr;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  d;
    int unsigned c;
  } exp_t;

  exp_t        q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [4:0]  exp_rom_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req_v, cyc);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rvalid !== 3'b000) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rvalid: got %b expected 000 at cycle %0d", rvalid, cyc);
        end else begin
          e = q.pop_front();
          chk("rvalid", {29'd0, rvalid}, {29'd0, e.v});
          chk("rdata", {27'd0, rdata}, {27'd0, e.d});
          chk("latency_cycle", cyc, e.c);
        end
      end
    end
  end

  // One cycle of stimulus: drive at negedge, check gnt, record expectation.
  task automatic step(input logic [2:0] r, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [2:0] lk, input logic [2:0] eg);
    logic [4:0] a;
    exp_t e;
    @(negedge clk);
    chk("rom_addr", {27'd0, rom_addr}, {27'd0, exp_rom_addr});
    req  = r;
    addr = {a2, a1, a0};
    lock = lk;
    #1;
    chk("gnt", {29'd0, gnt}, {29'd0, eg});
    if (eg != 3'b000) begin
      a = eg[0] ? a0 : (eg[1] ? a1 : a2);
      e.v = eg;
      e.d = ~a;
      e.c = cyc + 2;
      q.push_back(e);
      exp_rom_addr = a;
    end
  endtask

  initial begin
    resetn = 1'b0;
    req    = 3'b111;
    addr   = {5'h04, 5'h02, 5'h01};
    lock   = 3'b000;

    // Reset state with all requesters active.
    #12;
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
    chk("rst_rom_addr", {27'd0, rom_addr}, 32'd0);
    chk("rst_rdata", {27'd0, rdata}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    req    = 3'b000;

    // Single read by requester 1 (last=2 after reset).
    step(3'b010, 5'h00, 5'h03, 5'h00, 3'b000, 3'b010);

    // Idle gap: rdata and rom_addr hold.
    step(3'b000, 5'h00, 5'h00, 5'h00, 3'b000, 3'b000);
    step(3'b000, 5'h00, 5'h00, 5'h00, 3'b000, 3'b000);
    chk("idle_rdata_a", {27'd0, rdata}, 32'h1C);
    step(3'b000, 5'h00, 5'h00, 5'h00, 3'b000, 3'b000);
    chk("idle_rdata_b", {27'd0, rdata}, 32'h1C);
    chk("idle_rvalid", {29'd0, rvalid}, 32'd0);

    // Mid-operation reset: accepted read (requester 2) is dropped.
    step(3'b111, 5'h01, 5'h02, 5'h04, 3'b000, 3'b100);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_gnt", {29'd0, gnt}, 32'd0);
    chk("mid_rst_rvalid", {29'd0, rvalid}, 32'd0);
    chk("mid_rst_rom_addr", {27'd0, rom_addr}, 32'd0);
    chk("mid_rst_rdata", {27'd0, rdata}, 32'd0);
    q.delete();
    exp_rom_addr = '0;
    @(negedge clk);
    req    = 3'b000;
    resetn = 1'b1;
    step(3'b000, 5'h00, 5'h00, 5'h00, 3'b000, 3'b000);
    step(3'b000, 5'h00, 5'h00, 5'h00, 3'b000, 3'b000);

    // Contention: grants rotate 0,1,2.
    for (int i = 0; i < 2; i++) begin
      step(3'b111, 5'h01, 5'h02, 5'h04, 3'b000, 3'b001);
      step(3'b111, 5'h01, 5'h02, 5'h04, 3'b000, 3'b010);
      step(3'b111, 5'h01, 5'h02, 5'h04, 3'b000, 3'b100);
    end

    // Back-to-back stream from requester 0 across the full address range.
    for (int i = 0; i < 32; i++) begin
      step(3'b001, 5'(i), 5'h00, 5'h00, 3'b000, 3'b001);
    end

`ifdef ROM_ARB_LOCK_EN
    // Requester 2 locks for four reads; the fourth read releases the lock.
    step(3'b100, 5'h00, 5'h00, 5'h07, 3'b100, 3'b100);
    step(3'b111, 5'h01, 5'h02, 5'h08, 3'b100, 3'b100);
    step(3'b111, 5'h01, 5'h02, 5'h09, 3'b100, 3'b100);
    step(3'b111, 5'h01, 5'h02, 5'h0A, 3'b000, 3'b100);
    step(3'b111, 5'h05, 5'h02, 5'h0A, 3'b000, 3'b001);
`endif

    // Drain outstanding reads.
    for (int i = 0; i < 3; i++) begin
      step(3'b000, 5'h00, 5'h00, 5'h00, 3'b000, 3'b000);
    end
    chk("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
